// File: rtl/dmem_responder.sv
// Word-addressed data RAM behind a valid/ready request/response handshake.
// One access in flight; fixed wait states; byte-enabled stores; bad addresses flagged.
module dmem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q;
  logic [3:0]      cnt_q;
  logic            write_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic [3:0]      be_q;
  logic            resp_valid_q;
  logic [31:0]     resp_rdata_q;
  logic            resp_err_q;

  logic [31:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  addr_err;
  logic                  access;
  logic                  mem_we;

  assign idx      = addr_q[DEPTH_LOG2+1:2];
  assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q[31:DEPTH_LOG2+2] != '0);
  assign access   = (state_q == WAIT) && (cnt_q == 4'd0);
  assign mem_we   = access && write_q && !addr_err;

  assign req_ready  = (state_q == IDLE) && !reset;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  // RAM is deliberately left out of reset so it maps onto block memory.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem_q[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      write_q      <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      be_q         <= 4'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
            cnt_q   <= 4'(WAIT_CYCLES);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            // Stores and rejected accesses both answer with zero data.
            resp_rdata_q <= (!write_q && !addr_err) ? mem_q[idx] : 32'd0;
            resp_err_q   <= addr_err;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised and directed checks of dmem_responder against a word-array model.
// A second instance with zero wait states exercises back-to-back throughput.
module tb_dmem_responder;

  localparam int WC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic [3:0]  req_be = 4'd0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  logic        z_req_valid = 1'b0, z_req_write = 1'b0, z_resp_ready = 1'b0;
  logic [31:0] z_req_addr = 32'd0, z_req_wdata = 32'd0;
  logic [3:0]  z_req_be = 4'd0;
  logic        z_req_ready, z_resp_valid, z_resp_err;
  logic [31:0] z_resp_rdata;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] model [256];

  dmem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dmem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
    .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
    .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic exp_error(input logic [31:0] addr);
    return (addr % 4 != 0) || (addr >= 32'd1024);
  endfunction

  // Wait for IDLE, present one request and let it be taken on the next edge.
  task automatic accept(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be);
    for (int i = 0; i < 20 && !req_ready; i++) begin
      @(posedge clk); #1;
    end
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_be = be;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (resp_valid) begin
        lat = k;
        break;
      end
      chk("busy_ready", {31'd0, req_ready}, 32'd0);
    end
    chk("latency", lat, WC + 1);
  endtask

  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] be, input int hold);
    logic        e_err;
    logic [31:0] e_rd;
    int          lat;
    e_err = exp_error(addr);
    e_rd  = (!wr && !e_err) ? model[addr / 4] : 32'd0;
    accept(wr, addr, wd, be);
    if (wr && !e_err) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) model[addr / 4][8*i +: 8] = wd[8*i +: 8];
    end
    wait_resp(lat);
    if (lat == 0) return;
    chk("resp_rdata", resp_rdata, e_rd);
    chk("resp_err", {31'd0, resp_err}, {31'd0, e_err});
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, resp_valid}, 32'd1);
      chk("hold_rdata", resp_rdata, e_rd);
      chk("hold_err", {31'd0, resp_err}, {31'd0, e_err});
      chk("hold_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("post_valid", {31'd0, resp_valid}, 32'd0);
    chk("post_rdata", resp_rdata, 32'd0);
    chk("post_err", {31'd0, resp_err}, 32'd0);
    chk("post_ready", {31'd0, req_ready}, 32'd1);
    $display("txn wr=%0d addr=%h wdata=%h be=%h rdata=%h err=%0d lat=%0d",
             wr, addr, wd, be, e_rd, e_err, lat);
  endtask

  initial begin
    int acc_q[$];
    int rsp_q[$];
    int lat;
    logic [31:0] a;
    int r;
    for (int i = 0; i < 256; i++) model[i] = 32'd0;

    // Reset behaviour
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    reset = 1'b0;
    #1;
    chk("rel_ready", {31'd0, req_ready}, 32'd1);

    // Directed cases
    txn(1'b0, 32'h0, 32'h0, 4'h0, 0);
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    txn(1'b1, 32'h10, 32'h000000AA, 4'b0001, 0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0);
    txn(1'b1, 32'h14, 32'h55555555, 4'b0000, 0);
    txn(1'b0, 32'h13, 32'h0, 4'h0, 0);
    txn(1'b0, 32'h400, 32'h0, 4'h0, 0);
    txn(1'b1, 32'h400, 32'h12345678, 4'hF, 0);
    txn(1'b0, 32'h0, 32'h0, 4'h0, 0);
    txn(1'b0, 32'h3FC, 32'h0, 4'h0, 0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 5);

    // Reset one cycle after accepting a store: store must not land
    accept(1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    chk("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rel_ready", {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("mid_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    txn(1'b0, 32'h20, 32'h0, 4'h0, 0);

    // Reset during RESP: response dropped, store stands
    accept(1'b1, 32'h24, 32'h11223344, 4'hF);
    model[9] = 32'h11223344;
    wait_resp(lat);
    reset = 1'b1;
    #1;
    chk("resp_rst_valid", {31'd0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    txn(1'b0, 32'h24, 32'h0, 4'h0, 0);

    // Randomised traffic
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       a = 32'($urandom_range(0, 15)) * 4;
      else if (r == 7) a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
      else             a = 32'h400 + 32'($urandom_range(0, 255)) * 4;
      txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
          $urandom_range(0, 2));
    end

    // Zero-wait-state instance: held request and response ready
    z_resp_ready = 1'b1;
    z_req_valid = 1'b1;
    z_req_addr = 32'h8;
    for (int it = 0; it < 16; it++) begin
      if (acc_q.size() >= 4) z_req_valid = 1'b0;
      if (z_req_valid && z_req_ready) begin
        acc_q.push_back(cyc + 1);
        z_req_addr = 32'($urandom_range(0, 255)) * 4;
      end
      if (z_resp_valid) begin
        rsp_q.push_back(cyc);
        chk("z_rdata", z_resp_rdata, 32'd0);
        chk("z_err", {31'd0, z_resp_err}, 32'd0);
      end
      @(posedge clk); #1;
    end
    z_req_valid = 1'b0;
    chk("z_accepts", acc_q.size(), 4);
    chk("z_resps", rsp_q.size(), 4);
    for (int i = 0; i < 4 && i < acc_q.size() && i < rsp_q.size(); i++) begin
      chk("z_latency", rsp_q[i] - acc_q[i], 1);
      if (i > 0) chk("z_spacing", acc_q[i] - acc_q[i-1], 3);
      $display("z_txn idx=%0d accept=%0d resp=%0d", i, acc_q[i], rsp_q[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
